dmem_arbiter: RTL

- Two-requester arbiter and sequencer in front of the single-port 4096-entry data memory.
- Port A is the CPU load/store unit; port B is the DMA/debug loader.
- Accepts one request at a time via req/gnt, drives the memory's 2-bit write/read enable encodings, and returns read data with an rvalid pulse.
- Round-robin arbitration by default; a parameter selects fixed priority for A.

---
 rtl/dmem_arbiter_if.sv | 26 ++
 rtl/dmem_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bundle for one port of the data-memory arbiter.
// The requester drives the request fields and holds them until gnt.
// The arbiter returns gnt, plus rdata qualified by a one-cycle rvalid.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic              size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, size, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, size, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Port A is the CPU load/store unit, port B the DMA/debug loader.
//
// state  | meaning
// IDLE   | waiting for a request; winner's gnt is combinational
// ISSUE  | registered mem_* outputs carry the latched command
// RDWAIT | memory read data arrives; captured into the owner's rdata
// RESP   | owner's rvalid is high for this one cycle
module dmem_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_arbiter_if.slave     a,
  dmem_arbiter_if.slave     b,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_write_enable,
  output logic [1:0]        mem_read_enable,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_BYTE = 2'b01;
  localparam logic [1:0] WE_WORD = 2'b10;
  localparam logic [1:0] RE_BYTE = 2'b00;
  localparam logic [1:0] RE_WORD = 2'b01;
  localparam logic [1:0] RE_NONE = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

  state_t state, state_nxt;

  logic grant_a, grant_b, grant_any;
  logic last_b;
  logic cmd_we, cmd_size, cmd_owner_b;

  logic              sel_we, sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] rd_data;

  assign grant_any = grant_a | grant_b;
  assign a.gnt     = grant_a;
  assign b.gnt     = grant_b;

  assign sel_we    = grant_b ? b.we    : a.we;
  assign sel_size  = grant_b ? b.size  : a.size;
  assign sel_addr  = grant_b ? b.addr  : a.addr;
  assign sel_wdata = grant_b ? b.wdata : a.wdata;

  // Byte reads are zero-extended from the low byte of the memory word.
  assign rd_data = cmd_size ? mem_read_data
                            : {{(DATA_W-8){1'b0}}, mem_read_data[7:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and grant decode; grants are suppressed while reset is held.
  always_comb begin
    state_nxt = state;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    case (state)
      IDLE: begin
        if (reset_n) begin
          if (a.req && (!b.req || (FIXED_PRIO != 0) || last_b)) grant_a = 1'b1;
          else if (b.req)                                      grant_b = 1'b1;
          if (grant_a || grant_b) state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = cmd_we ? IDLE : RDWAIT;
      RDWAIT:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch and round-robin pointer, updated on every grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_we      <= 1'b0;
      cmd_size    <= 1'b0;
      cmd_owner_b <= 1'b0;
      last_b      <= 1'b1;
    end else if (grant_any) begin
      cmd_we      <= sel_we;
      cmd_size    <= sel_size;
      cmd_owner_b <= grant_b;
      last_b      <= grant_b;
    end
  end

  // Memory bus: enables are active only during ISSUE, addr/data hold otherwise.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_addr         <= '0;
      mem_write_data   <= '0;
      mem_write_enable <= WE_NONE;
      mem_read_enable  <= RE_NONE;
    end else begin
      mem_write_enable <= WE_NONE;
      mem_read_enable  <= RE_NONE;
      if (grant_any) begin
        mem_addr       <= sel_addr;
        mem_write_data <= sel_size ? sel_wdata
                                   : {{(DATA_W-8){1'b0}}, sel_wdata[7:0]};
        if (sel_we) mem_write_enable <= sel_size ? WE_WORD : WE_BYTE;
        else        mem_read_enable  <= sel_size ? RE_WORD : RE_BYTE;
      end
    end
  end

  // Read return: capture in RDWAIT so rvalid and rdata appear together in RESP.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a.rvalid <= 1'b0;
      b.rvalid <= 1'b0;
      a.rdata  <= '0;
      b.rdata  <= '0;
    end else begin
      a.rvalid <= 1'b0;
      b.rvalid <= 1'b0;
      if (state == RDWAIT) begin
        if (cmd_owner_b) begin
          b.rdata  <= rd_data;
          b.rvalid <= 1'b1;
        end else begin
          a.rdata  <= rd_data;
          a.rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
